fnd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode FND.
- Cycles the 2-bit digit select through 0..3 with programmable on-time and inter-digit blanking.
- Drives the active-low digit commons (the same one-hot-low code as the digit decoder) and presents the BCD nibble and decimal point for the active digit to the segment decoder.
- Sits between the FSM/counter datapath, which supplies four BCD digits, and the FND pins.

---
 rtl/fnd_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode FND.
//
// Cycles the digit select 0..3. Each digit gets BLANK_TICKS cycles with every
// common off, followed by DIGIT_TICKS cycles lit. i_bcd/i_dp are snapshotted
// only at frame start, so the display never tears mid-frame.
//
// Optional feature (compile-time macro FND_LZ_BLANK_EN): leading-zero
// suppression. Digits 3..1 stay dark while their nibble and every higher nibble
// are zero and no decimal point at or above them is set. Digit 0 always lights.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_enable       scan enable; 0 forces the display dark and restarts the scan
//   i_bcd[15:0]    four BCD digits, [3:0] = digit 0 (rightmost)
//   i_dp[3:0]      decimal point per digit, active-high
//   o_digitsel     index of the current digit
//   o_com[3:0]     active-low digit commons
//   o_bcd[3:0]     nibble of the current digit (from snapshot)
//   o_dp           decimal point of the current digit (from snapshot)
//   o_frame_start  one-cycle pulse when a new snapshot is taken
module fnd_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  output logic [1:0]  o_digitsel,
  output logic [3:0]  o_com,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame_start
);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 32'd1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_TICKS == 32'd0) ? 32'd0 : BLANK_TICKS - 32'd1);
  localparam bit HAS_BLANK = (BLANK_TICKS != 32'd0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dsel_q, dsel_d;
  logic [15:0]      snap_bcd_q, snap_bcd_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       com_q, com_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;
  logic             digit_lit;

  // Whether the digit about to be shown should actually light its common
`ifdef FND_LZ_BLANK_EN
  logic [3:0] lz_dark;

  always_comb begin
    lz_dark[3] = (snap_bcd_d[15:12] == 4'd0) && !snap_dp_d[3];
    lz_dark[2] = lz_dark[3] && (snap_bcd_d[11:8] == 4'd0) && !snap_dp_d[2];
    lz_dark[1] = lz_dark[2] && (snap_bcd_d[7:4] == 4'd0) && !snap_dp_d[1];
    lz_dark[0] = 1'b0;
    digit_lit  = !lz_dark[dsel_d];
  end
`else
  assign digit_lit = 1'b1;
`endif

  // Next-state, counter, snapshot and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dsel_d     = dsel_q;
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;
    fs_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          dsel_d     = 2'd0;
          snap_bcd_d = i_bcd;
          snap_dp_d  = i_dp;
          fs_d       = 1'b1;
          cnt_d      = '0;
          state_d    = HAS_BLANK ? S_BLANK : S_SHOW;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_d  = '0;
          dsel_d = dsel_q + 2'd1;
          // Wrapping back to digit 0 starts a new frame
          if (dsel_q == 2'd3) begin
            snap_bcd_d = i_bcd;
            snap_dp_d  = i_dp;
            fs_d       = 1'b1;
          end
          state_d = HAS_BLANK ? S_BLANK : S_SHOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        dsel_d  = 2'd0;
      end
    endcase

    // Dropping enable parks the scan; the snapshot is kept
    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dsel_d  = 2'd0;
      fs_d    = 1'b0;
    end

    // Outputs track the digit being entered so they change with o_digitsel
    bcd_d = snap_bcd_d[{dsel_d, 2'b00} +: 4];
    dp_d  = snap_dp_d[dsel_d];
    com_d = 4'b1111;
    if (state_d == S_SHOW && digit_lit) begin
      com_d = ~(4'b0001 << dsel_d);
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dsel_q     <= 2'd0;
      snap_bcd_q <= 16'd0;
      snap_dp_q  <= 4'd0;
      com_q      <= 4'b1111;
      bcd_q      <= 4'd0;
      dp_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dsel_q     <= dsel_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      com_q      <= com_d;
      bcd_q      <= bcd_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign o_digitsel    = dsel_q;
  assign o_com         = com_q;
  assign o_bcd         = bcd_q;
  assign o_dp          = dp_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl. Two instances share the stimulus: one with
// blanking (DIGIT_TICKS=4, BLANK_TICKS=1) and one without (DIGIT_TICKS=2,
// BLANK_TICKS=0). Expected outputs come from a frame-position model: cycles
// since frame start, split into per-digit slots of blank + lit time.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp;

  logic [1:0] dsel_a, dsel_b;
  logic [3:0] com_a, com_b, bcd_a, bcd_b;
  logic       dp_a, dp_b, fs_a, fs_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.DIGIT_TICKS(4), .BLANK_TICKS(1), .CNT_W(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_bcd(bcd), .i_dp(dp),
    .o_digitsel(dsel_a), .o_com(com_a), .o_bcd(bcd_a), .o_dp(dp_a),
    .o_frame_start(fs_a)
  );

  fnd_scan_ctrl #(.DIGIT_TICKS(2), .BLANK_TICKS(0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_bcd(bcd), .i_dp(dp),
    .o_digitsel(dsel_b), .o_com(com_b), .o_bcd(bcd_b), .o_dp(dp_b),
    .o_frame_start(fs_b)
  );

  // Reference model state, one slot per instance
  int          m_d[2]   = '{4, 2};
  int          m_b[2]   = '{1, 0};
  bit          m_act[2];
  bit          m_rst_idle[2];
  int          m_t[2];
  logic [15:0] m_snap[2];
  logic [3:0]  m_sdp[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int per;
      per = 4 * (m_d[k] + m_b[k]);
      if (rst) begin
        m_act[k] = 0; m_rst_idle[k] = 1; m_snap[k] = 0; m_sdp[k] = 0;
      end else if (!en) begin
        m_act[k] = 0; m_rst_idle[k] = 0;
      end else if (!m_act[k]) begin
        m_act[k] = 1; m_t[k] = 0; m_snap[k] = bcd; m_sdp[k] = dp;
      end else begin
        m_t[k]++;
        if (m_t[k] % per == 0) begin
          m_snap[k] = bcd; m_sdp[k] = dp;
        end
      end
    end
  endtask

  function automatic bit suppressed(input int k, input int d);
`ifdef FND_LZ_BLANK_EN
    if (d == 0) return 0;
    return ((m_snap[k] >> (4 * d)) == 0) && ((m_sdp[k] >> d) == 0);
`else
    return 0;
`endif
  endfunction

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] e_com, e_bcd, g_com, g_bcd;
      logic [1:0] e_dsel, g_dsel;
      logic       e_dp, e_fs, g_dp, g_fs;
      int slot, p, d, w;
      string s;
      s = (k == 0) ? "a" : "b";
      g_com  = (k == 0) ? com_a  : com_b;
      g_bcd  = (k == 0) ? bcd_a  : bcd_b;
      g_dsel = (k == 0) ? dsel_a : dsel_b;
      g_dp   = (k == 0) ? dp_a   : dp_b;
      g_fs   = (k == 0) ? fs_a   : fs_b;
      if (!m_act[k]) begin
        chk({s, ".idle_com"}, 32'(g_com), 32'hF);
        chk({s, ".idle_dsel"}, 32'(g_dsel), 32'd0);
        chk({s, ".idle_fs"}, 32'(g_fs), 32'd0);
        if (m_rst_idle[k]) begin
          chk({s, ".rst_bcd"}, 32'(g_bcd), 32'd0);
          chk({s, ".rst_dp"}, 32'(g_dp), 32'd0);
        end
      end else begin
        slot = m_d[k] + m_b[k];
        p = m_t[k] % (4 * slot);
        d = p / slot;
        w = p % slot;
        e_dsel = 2'(d);
        e_bcd  = 4'((m_snap[k] >> (4 * d)) & 16'hF);
        e_dp   = m_sdp[k][d];
        e_fs   = (p == 0);
        e_com  = (w < m_b[k] || suppressed(k, d)) ? 4'hF : ~(4'(1) << d);
        chk({s, ".com"}, 32'(g_com), 32'(e_com));
        chk({s, ".dsel"}, 32'(g_dsel), 32'(e_dsel));
        chk({s, ".bcd"}, 32'(g_bcd), 32'(e_bcd));
        chk({s, ".dp"}, 32'(g_dp), 32'(e_dp));
        chk({s, ".fs"}, 32'(g_fs), 32'(e_fs));
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_rst_idle[k] = 0; m_t[k] = 0; m_snap[k] = 0; m_sdp[k] = 0;
    end
    rst = 1'b1; en = 1'b1; bcd = 16'h1234; dp = 4'h0;
    step(3);
    rst = 1'b0;
    step(8);
    bcd = 16'h5678;            // lands mid-frame; must wait for next frame
    step(40);
    dp = 4'b0100;
    step(40);
    step(12);
    en = 1'b0;                 // drop mid-frame
    step(3);
    en = 1'b1;
    step(30);
    dp = 4'h0; bcd = 16'h0045;
    step(40);
    bcd = 16'h0000;
    step(40);
    bcd = 16'h0045; dp = 4'b0100;
    step(40);
    bcd = 16'hABCD; dp = 4'h0;
    step(10);
    rst = 1'b1;                // reset mid-SHOW
    step(1);
    rst = 1'b0;
    step(30);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) begin
        // bias towards leading zeros
        bcd = 16'($urandom) >> (4 * $urandom_range(0, 4));
      end
      if ($urandom_range(0, 7) == 0) begin
        dp = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
